// File: rtl/clkdiv_slow_fifo.sv
// Fast-domain FIFO whose head is presented to a divided slow clock on update edges.
// Optional macro CLKDIV_SLOW_FIFO_DROP_CNT_EN adds a saturating refused-write counter.
module clkdiv_slow_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              preedge_i,
    input  logic              enq_valid_i,
    input  logic [DATA_W-1:0] enq_data_i,
    output logic              enq_ready_o,
    output logic              slow_valid_o,
    output logic [DATA_W-1:0] slow_data_o,
    input  logic              slow_deq_i,
`ifdef CLKDIV_SLOW_FIFO_DROP_CNT_EN
    output logic [7:0]        drop_cnt_o,
`endif
    output logic [AW:0]       count_o
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] ring [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_next;
    logic              push;
    logic              consumed;
    logic              pop;

    // The pop decision uses the registered count, so a word written on an
    // update edge cannot bypass into the output register on that same edge.
    assign push     = enq_valid_i & enq_ready_o;
    assign consumed = slow_valid_o & slow_deq_i;
    assign pop      = preedge_i & (~slow_valid_o | consumed) & (count_o != '0);

    always_comb begin
        count_next = count_o;
        case ({push, pop})
            2'b10:   count_next = count_o + 1'b1;
            2'b01:   count_next = count_o - 1'b1;
            default: count_next = count_o;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            ring[wr_ptr] <= enq_data_i;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_o      <= '0;
            enq_ready_o  <= 1'b1;
            slow_valid_o <= 1'b0;
            slow_data_o  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                slow_data_o  <= ring[rd_ptr];
                slow_valid_o <= 1'b1;
            end else if (preedge_i && consumed) begin
                slow_valid_o <= 1'b0;
            end
            count_o     <= count_next;
            enq_ready_o <= (count_next < FULL_COUNT);
        end
    end

`ifdef CLKDIV_SLOW_FIFO_DROP_CNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_cnt_o <= 8'd0;
        end else if (enq_valid_i && !enq_ready_o && (drop_cnt_o != 8'hFF)) begin
            drop_cnt_o <= drop_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clkdiv_slow_fifo.sv
// Table-driven bench for clkdiv_slow_fifo with divide-by-3 update edges.
// Checks drop_cnt_o as well when CLKDIV_SLOW_FIFO_DROP_CNT_EN is defined.
module tb_clkdiv_slow_fifo;

    logic        CLK;
    logic        RST_N;
    logic        preedge_i;
    logic        enq_valid_i;
    logic [31:0] enq_data_i;
    logic        enq_ready_o;
    logic        slow_valid_o;
    logic [31:0] slow_data_o;
    logic        slow_deq_i;
    logic [2:0]  count_o;
`ifdef CLKDIV_SLOW_FIFO_DROP_CNT_EN
    logic [7:0]  drop_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        pre;
        logic        valid;
        logic [31:0] data;
        logic        deq;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs[$];

    clkdiv_slow_fifo #(.DATA_W(32), .DEPTH(4)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .preedge_i    (preedge_i),
        .enq_valid_i  (enq_valid_i),
        .enq_data_i   (enq_data_i),
        .enq_ready_o  (enq_ready_o),
        .slow_valid_o (slow_valid_o),
        .slow_data_o  (slow_data_o),
        .slow_deq_i   (slow_deq_i),
`ifdef CLKDIV_SLOW_FIFO_DROP_CNT_EN
        .drop_cnt_o   (drop_cnt_o),
`endif
        .count_o      (count_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic r, input logic v,
                               input logic [31:0] d, input logic [2:0] c);
        check_output({tag, "_ready"}, {31'd0, enq_ready_o}, {31'd0, r});
        check_output({tag, "_valid"}, {31'd0, slow_valid_o}, {31'd0, v});
        check_output({tag, "_data"}, slow_data_o, d);
        check_output({tag, "_count"}, {29'd0, count_o}, {29'd0, c});
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic apply_stimulus(input logic pre, input logic valid,
                                  input logic [31:0] data, input logic deq);
        preedge_i   = pre;
        enq_valid_i = valid;
        enq_data_i  = data;
        slow_deq_i  = deq;
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input logic pre, input logic valid, input logic [31:0] data,
                                input logic deq, input logic r, input logic v,
                                input logic [31:0] d, input logic [2:0] c);
        vec_t t;
        t.pre = pre; t.valid = valid; t.data = data; t.deq = deq;
        t.exp_ready = r; t.exp_valid = v; t.exp_data = d; t.exp_count = c;
        return t;
    endfunction

    initial begin
        // single word, stable hold, consume
        vecs.push_back(mk(0, 1, 32'hA5, 0, 1, 0, 32'h00, 1));
        vecs.push_back(mk(1, 0, 32'h00, 0, 1, 1, 32'hA5, 0));
        vecs.push_back(mk(0, 0, 32'h00, 0, 1, 1, 32'hA5, 0));
        vecs.push_back(mk(0, 0, 32'h00, 0, 1, 1, 32'hA5, 0));
        vecs.push_back(mk(1, 0, 32'h00, 0, 1, 1, 32'hA5, 0));
        vecs.push_back(mk(0, 0, 32'h00, 0, 1, 1, 32'hA5, 0));
        vecs.push_back(mk(0, 0, 32'h00, 0, 1, 1, 32'hA5, 0));
        vecs.push_back(mk(1, 0, 32'h00, 1, 1, 0, 32'hA5, 0));
        // fill with no dequeue: 0 goes out, ring holds 1..4, 5 and 6 refused
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 0, 32'hA5, 1));
        vecs.push_back(mk(0, 1, 32'h01, 0, 1, 0, 32'hA5, 2));
        vecs.push_back(mk(1, 1, 32'h02, 0, 1, 1, 32'h00, 2));
        vecs.push_back(mk(0, 1, 32'h03, 0, 1, 1, 32'h00, 3));
        vecs.push_back(mk(0, 1, 32'h04, 0, 0, 1, 32'h00, 4));
        vecs.push_back(mk(1, 1, 32'h05, 0, 0, 1, 32'h00, 4));
        vecs.push_back(mk(0, 1, 32'h06, 0, 0, 1, 32'h00, 4));
        vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1, 32'h00, 4));
        // collision on update edge with full ring: pop, ready rises after the edge
        vecs.push_back(mk(1, 1, 32'h07, 1, 1, 1, 32'h01, 3));
        vecs.push_back(mk(0, 1, 32'h07, 0, 0, 1, 32'h01, 4));
        // dequeue on a non-update cycle is ignored
        vecs.push_back(mk(0, 0, 32'h00, 1, 0, 1, 32'h01, 4));
        // drain with dequeue held
        vecs.push_back(mk(1, 0, 32'h00, 1, 1, 1, 32'h02, 3));
        vecs.push_back(mk(0, 0, 32'h00, 1, 1, 1, 32'h02, 3));
        vecs.push_back(mk(0, 0, 32'h00, 1, 1, 1, 32'h02, 3));
        vecs.push_back(mk(1, 0, 32'h00, 1, 1, 1, 32'h03, 2));
        vecs.push_back(mk(0, 0, 32'h00, 1, 1, 1, 32'h03, 2));
        vecs.push_back(mk(0, 0, 32'h00, 1, 1, 1, 32'h03, 2));
        vecs.push_back(mk(1, 0, 32'h00, 1, 1, 1, 32'h04, 1));
        vecs.push_back(mk(0, 0, 32'h00, 1, 1, 1, 32'h04, 1));
        vecs.push_back(mk(0, 0, 32'h00, 1, 1, 1, 32'h04, 1));
        vecs.push_back(mk(1, 0, 32'h00, 1, 1, 1, 32'h07, 0));
        vecs.push_back(mk(0, 0, 32'h00, 1, 1, 1, 32'h07, 0));
        vecs.push_back(mk(0, 0, 32'h00, 1, 1, 1, 32'h07, 0));
        vecs.push_back(mk(1, 0, 32'h00, 1, 1, 0, 32'h07, 0));
        vecs.push_back(mk(0, 0, 32'h00, 0, 1, 0, 32'h07, 0));

        RST_N       = 1'b0;
        preedge_i   = 1'b0;
        enq_valid_i = 1'b0;
        enq_data_i  = 32'd0;
        slow_deq_i  = 1'b0;
        #22;
        check_state("reset", 1, 0, 32'h0, 0);
`ifdef CLKDIV_SLOW_FIFO_DROP_CNT_EN
        check_output("reset_drop", {24'd0, drop_cnt_o}, 32'd0);
`endif
        RST_N = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].pre, vecs[i].valid, vecs[i].data, vecs[i].deq);
            check_state($sformatf("row%0d", i), vecs[i].exp_ready, vecs[i].exp_valid,
                        vecs[i].exp_data, vecs[i].exp_count);
        end
`ifdef CLKDIV_SLOW_FIFO_DROP_CNT_EN
        check_output("drop_after_fill", {24'd0, drop_cnt_o}, 32'd3);
`endif

        // queue three entries behind a loaded output register, then reset mid-stream
        apply_stimulus(0, 1, 32'h11, 0);
        apply_stimulus(1, 1, 32'h22, 0);
        check_state("prerst_a", 1, 1, 32'h11, 1);
        apply_stimulus(0, 1, 32'h33, 0);
        apply_stimulus(0, 1, 32'h44, 0);
        check_state("prerst_b", 1, 1, 32'h11, 3);
        enq_valid_i = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        check_state("midrst", 1, 0, 32'h0, 0);
`ifdef CLKDIV_SLOW_FIFO_DROP_CNT_EN
        check_output("midrst_drop", {24'd0, drop_cnt_o}, 32'd0);
`endif
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RST_N = 1'b1;
        for (int k = 0; k < 9; k++) begin
            apply_stimulus((k % 3) == 2, 0, 32'h0, 1);
        end
        check_state("postrst", 1, 0, 32'h0, 0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
